// File: rtl/dlfloat16_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input and
// the valid/ready instruction stream toward the decoder.
interface dlfloat16_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, fifo_count,
        input  imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, fifo_count,
        output imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/dlfloat16_fetch_unit.sv
// Instruction fetch: PC, 1-cycle-latency memory read, prefetch FIFO of
// {instr, pc} pairs and a flushing redirect path feeding the decoder.
module dlfloat16_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dlfloat16_fetch_unit_if.master bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(DEPTH);

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(4);
    endfunction

    logic [ADDR_W-1:0] pc_p0;
    logic              issue_p0;
    logic [CNT_W:0]    occ_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic              push_p1;

    logic [31:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;

    // p0: issue stage. Outstanding request is counted against free space so a
    // response can always be pushed; same-cycle pops are deliberately ignored.
    assign occ_p0   = {1'b0, count} + (CNT_W + 1)'(vld_p1);
    assign issue_p0 = rst_n & ~bus.redirect & (occ_p0 < DEPTH_L);

    // p1: memory response stage; a redirect drops the in-flight word.
    assign push_p1  = vld_p1 & ~bus.redirect;
    assign pop      = bus.instr_valid & bus.instr_ready & ~bus.redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.redirect) begin
            pc_p0  <= align_pc(bus.redirect_pc);
            vld_p1 <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            vld_p1 <= issue_p0;
            if (issue_p0) begin
                pc_p0 <= next_pc(pc_p0);
            end
            if (push_p1) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_p1, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue_p0) begin
            pc_p1 <= pc_p0;
        end
        if (push_p1) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= pc_p1;
        end
    end

    // p2: FIFO head presented combinationally; everything is forced quiet in reset.
    assign bus.imem_req    = issue_p0;
    assign bus.imem_addr   = pc_p0;
    assign bus.instr_valid = rst_n & (count != '0);
    assign bus.instr       = rst_n ? fifo_instr[rd_ptr] : '0;
    assign bus.instr_pc    = rst_n ? fifo_pc[rd_ptr] : '0;
    assign bus.fifo_count  = rst_n ? count : '0;
endmodule

// File: tb/tb_dlfloat16_fetch_unit.sv
// Directed bench for dlfloat16_fetch_unit: cycle table plus hand-written
// random-ready, reset-vector-wrap and overflow watch sequences.
module tb_dlfloat16_fetch_unit;
    logic clk;
    logic rst_na;
    logic rst_nb;
    int   total;
    int   bad;
    int   mode;
    logic prev_req_a;

    dlfloat16_fetch_unit_if #(.ADDR_W(32), .DEPTH(4)) ifa ();
    dlfloat16_fetch_unit_if #(.ADDR_W(32), .DEPTH(4)) ifb ();

    dlfloat16_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (ifa)
    );

    dlfloat16_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (ifb)
    );

    function automatic logic [31:0] word(input int m, input logic [31:0] a);
        if (m == 0) return 32'h1000_0000 | a;
        return {7'b0000000, a[6:2], a[11:7], 3'b000, a[6:2] ^ 5'h1F, 7'b1011011};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ifa.imem_req) ifa.imem_rdata <= word(mode, ifa.imem_addr);
        if (ifb.imem_req) ifb.imem_rdata <= word(0, ifb.imem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A push into a full FIFO without a same-cycle pop would be an overflow.
    always @(negedge clk) begin
        #2;
        if (rst_na && prev_req_a && !ifa.redirect) begin
            total++;
            if (ifa.fifo_count == 3'd4 && !(ifa.instr_valid && ifa.instr_ready)) begin
                bad++;
                $display("FAIL overflow: got count %0d with push and no pop, expected room", ifa.fifo_count);
            end
        end
        prev_req_a = rst_na & ifa.imem_req;
    end

    typedef struct packed {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic rdir,
                                input logic [31:0] rpc, input logic q,
                                input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic [2:0] c);
        vec_t t;
        t.rst_n = r; t.ready = rd; t.redir = rdir; t.rpc = rpc;
        t.req = q; t.addr = a; t.valid = v; t.ipc = p; t.cnt = c;
        return t;
    endfunction

    localparam int NV = 31;
    vec_t tbl [NV];

    initial begin
        int n;
        int pops;
        logic [31:0] exp_pc;

        total = 0; bad = 0; mode = 0; prev_req_a = 1'b0;
        rst_na = 1'b0; rst_nb = 1'b0;
        ifa.instr_ready = 1'b0; ifa.redirect = 1'b0; ifa.redirect_pc = '0;
        ifb.instr_ready = 1'b1; ifb.redirect = 1'b0; ifb.redirect_pc = '0;

        //            rst rdy rdr rpc        req addr        vld ipc         cnt
        tbl[0]  = mk(1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   3'd0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   3'd0);
        tbl[2]  = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h0,   1'b0,32'h0,   3'd0);
        tbl[3]  = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h4,   1'b0,32'h0,   3'd0);
        tbl[4]  = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h8,   1'b1,32'h0,   3'd1);
        tbl[5]  = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'hC,   1'b1,32'h0,   3'd2);
        tbl[6]  = mk(1'b1,1'b0,1'b0,32'h0,   1'b0,32'h10,  1'b1,32'h0,   3'd3);
        tbl[7]  = mk(1'b1,1'b0,1'b0,32'h0,   1'b0,32'h10,  1'b1,32'h0,   3'd4);
        tbl[8]  = mk(1'b1,1'b1,1'b0,32'h0,   1'b0,32'h10,  1'b1,32'h0,   3'd4);
        tbl[9]  = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h10,  1'b1,32'h4,   3'd3);
        tbl[10] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h14,  1'b1,32'h8,   3'd2);
        tbl[11] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h18,  1'b1,32'hC,   3'd2);
        tbl[12] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h1C,  1'b1,32'h10,  3'd2);
        tbl[13] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h20,  1'b1,32'h14,  3'd2);
        tbl[14] = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h24,  1'b1,32'h18,  3'd2);
        tbl[15] = mk(1'b1,1'b0,1'b1,32'h40,  1'b0,32'h28,  1'b1,32'h18,  3'd3);
        tbl[16] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h40,  1'b0,32'h0,   3'd0);
        tbl[17] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h44,  1'b0,32'h0,   3'd0);
        tbl[18] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h48,  1'b1,32'h40,  3'd1);
        tbl[19] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h4C,  1'b1,32'h44,  3'd1);
        tbl[20] = mk(1'b1,1'b1,1'b1,32'h100, 1'b0,32'h50,  1'b1,32'h48,  3'd1);
        tbl[21] = mk(1'b1,1'b1,1'b1,32'h43,  1'b0,32'h100, 1'b0,32'h0,   3'd0);
        tbl[22] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h40,  1'b0,32'h0,   3'd0);
        tbl[23] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h44,  1'b0,32'h0,   3'd0);
        tbl[24] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h48,  1'b1,32'h40,  3'd1);
        tbl[25] = mk(1'b1,1'b1,1'b0,32'h0,   1'b1,32'h4C,  1'b1,32'h44,  3'd1);
        tbl[26] = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h50,  1'b1,32'h48,  3'd1);
        tbl[27] = mk(1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   3'd0);
        tbl[28] = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h0,   1'b0,32'h0,   3'd0);
        tbl[29] = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h4,   1'b0,32'h0,   3'd0);
        tbl[30] = mk(1'b1,1'b0,1'b0,32'h0,   1'b1,32'h8,   1'b1,32'h0,   3'd1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_na          = tbl[i].rst_n;
            ifa.instr_ready = tbl[i].ready;
            ifa.redirect    = tbl[i].redir;
            ifa.redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("v%0d req", i), 32'(ifa.imem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d valid", i), 32'(ifa.instr_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d count", i), 32'(ifa.fifo_count), 32'(tbl[i].cnt));
            if (tbl[i].rst_n) begin
                chk($sformatf("v%0d addr", i), ifa.imem_addr, tbl[i].addr);
            end else begin
                chk($sformatf("v%0d rst_instr", i), ifa.instr, 32'h0);
                chk($sformatf("v%0d rst_instr_pc", i), ifa.instr_pc, 32'h0);
            end
            if (tbl[i].valid) begin
                chk($sformatf("v%0d instr_pc", i), ifa.instr_pc, tbl[i].ipc);
                chk($sformatf("v%0d instr", i), ifa.instr, word(0, tbl[i].ipc));
            end
        end

        // Add-class stream under random consumer back-pressure.
        @(negedge clk);
        rst_na = 1'b0; ifa.instr_ready = 1'b0; ifa.redirect = 1'b0;
        mode = 1;
        @(negedge clk);
        rst_na = 1'b1;
        exp_pc = 32'h0;
        pops = 0;
        for (int c = 0; c < 200; c++) begin
            ifa.instr_ready = 1'($urandom_range(0, 1));
            #1;
            if (ifa.instr_valid && ifa.instr_ready) begin
                chk("rnd instr_pc", ifa.instr_pc, exp_pc);
                chk("rnd instr", ifa.instr, word(1, exp_pc));
                chk("rnd opcode", 32'(ifa.instr[6:0]), 32'h5B);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        chk("rnd enough pops", 32'(pops >= 40), 32'd1);

        // Reset vector near the top of the address space wraps to zero.
        rst_nb = 1'b1;
        #1;
        n = 0;
        while (!ifb.instr_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wrap first valid latency", 32'(n), 32'd2);
        if (ifb.instr_valid) begin
            exp_pc = 32'hFFFF_FFF8;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wrap%0d valid", k), 32'(ifb.instr_valid), 32'd1);
                chk($sformatf("wrap%0d instr_pc", k), ifb.instr_pc, exp_pc);
                chk($sformatf("wrap%0d instr", k), ifb.instr, word(0, exp_pc));
                exp_pc = exp_pc + 32'd4;
                @(negedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
